max_run_finder: RTL

Parametrised serial scanner that finds the longest run of consecutive target bits in a loaded word. The target bit is selectable: ones or zeros. It reports both the run length and the bit index where the run starts, and stops early once the best run can no longer be beaten. It replaces the fixed 32-bit ones-only max-string counter and uses the same start/busy/done handshake.

---
 rtl/max_run_finder_pkg.sv | 14 +
 rtl/max_run_finder_if.sv | 27 ++
 rtl/max_run_ctrl.sv | 73 +++++++
 rtl/max_run_finder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/max_run_finder_pkg.sv
// Shared definitions for the max_run_finder block: FSM state encoding and
// the target-bit mode constants.
package max_run_finder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ZEROS = 1'b0;
  localparam logic MODE_ONES  = 1'b1;

endpackage

// File: rtl/max_run_finder_if.sv
// Start/busy/done handshake plus data and result bus of max_run_finder.
// The master drives the request; the slave (the scanner) returns results.
interface max_run_finder_if #(
  parameter int word_size    = 32,
  parameter int counter_size = 6,
  parameter int index_size   = 5
);

  logic                    start;
  logic                    mode;
  logic [word_size-1:0]    data;
  logic [counter_size-1:0] run_length;
  logic [index_size-1:0]   run_start;
  logic                    busy;
  logic                    done;

  modport master (
    output start, mode, data,
    input  run_length, run_start, busy, done
  );

  modport slave (
    input  start, mode, data,
    output run_length, run_start, busy, done
  );

endinterface

// File: rtl/max_run_ctrl.sv
// Control FSM for max_run_finder: accepts start in IDLE/DONE, keeps scanning
// until the datapath raises stop, and produces registered busy/done.
module max_run_ctrl
  import max_run_finder_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic busy,
  output logic done,
  output logic load,
  output logic clear,
  output logic shift_en,
  output logic capture
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  // Next-state and strobe decode; busy/done follow the next state so they are
  // registered copies of the state itself.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    clear    = 1'b0;
    shift_en = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          clear   = 1'b1;
          state_d = SCAN;
        end else begin
          state_d = state_q;
        end
      end
      SCAN: begin
        shift_en = 1'b1;
        if (stop) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SCAN) ? 1'b1 : 1'b0;
    done_d = (state_d == DONE) ? 1'b1 : 1'b0;
  end

  // State and handshake output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/max_run_finder.sv
// Serial longest-run scanner. Scans the loaded word LSB first, tracking the
// current and best run of the selected target bit, and stops as soon as the
// best run can no longer be beaten by the remaining bits.
module max_run_finder
  import max_run_finder_pkg::*;
#(
  parameter int word_size    = 32,
  parameter int counter_size = 6,
  parameter int index_size   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  max_run_finder_if.slave      bus
);

  // Wide enough for cur + remaining-bits and for pos + 1 - cur without wrap.
  localparam int AW = ((counter_size > index_size) ? counter_size : index_size) + 1;
  localparam logic [counter_size-1:0] CNT_ONE  = counter_size'(1);
  localparam logic [index_size-1:0]   POS_ONE  = index_size'(1);
  localparam logic [index_size-1:0]   POS_LAST = index_size'(word_size - 1);

  logic                    load, clear, shift_en, capture, stop;

  logic [word_size-1:0]    shift_q, shift_d;
  logic                    mode_q, mode_d;
  logic [index_size-1:0]   pos_q, pos_d;
  logic [counter_size-1:0] cur_q, cur_d;
  logic [counter_size-1:0] best_q, best_d;
  logic [index_size-1:0]   best_start_q, best_start_d;
  logic [counter_size-1:0] run_length_q, run_length_d;
  logic [index_size-1:0]   run_start_q, run_start_d;

  logic [counter_size-1:0] cur_n, best_n;
  logic [index_size-1:0]   best_start_n;
  logic [AW-1:0]           start_calc, rem, reach;

  max_run_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (bus.start),
    .stop     (stop),
    .busy     (bus.busy),
    .done     (bus.done),
    .load     (load),
    .clear    (clear),
    .shift_en (shift_en),
    .capture  (capture)
  );

  // One scan step on the current LSB: run update, best update, stop decision.
  always_comb begin
    cur_n        = (shift_q[0] == mode_q) ? (cur_q + CNT_ONE) : '0;
    start_calc   = AW'(pos_q) + AW'(1'b1) - AW'(cur_n);
    if (cur_n > best_q) begin
      best_n       = cur_n;
      best_start_n = start_calc[index_size-1:0];
    end else begin
      best_n       = best_q;
      best_start_n = best_start_q;
    end
    rem   = AW'(word_size - 1) - AW'(pos_q);
    reach = AW'(cur_n) + rem;
    stop  = (pos_q == POS_LAST) || (reach <= AW'(best_n));
  end

  // Datapath next-state: load/clear on an accepted start, advance while scanning,
  // publish results when the scan finishes.
  always_comb begin
    shift_d      = shift_q;
    mode_d       = mode_q;
    pos_d        = pos_q;
    cur_d        = cur_q;
    best_d       = best_q;
    best_start_d = best_start_q;
    run_length_d = run_length_q;
    run_start_d  = run_start_q;
    if (load) begin
      shift_d = bus.data;
      mode_d  = bus.mode;
    end else if (shift_en) begin
      shift_d = shift_q >> 1;
    end else begin
      shift_d = shift_q;
    end
    if (clear) begin
      pos_d        = '0;
      cur_d        = '0;
      best_d       = '0;
      best_start_d = '0;
    end else if (shift_en) begin
      pos_d        = (pos_q == POS_LAST) ? pos_q : (pos_q + POS_ONE);
      cur_d        = cur_n;
      best_d       = best_n;
      best_start_d = best_start_n;
    end else begin
      pos_d        = pos_q;
    end
    if (capture) begin
      run_length_d = best_n;
      run_start_d  = best_start_n;
    end else begin
      run_length_d = run_length_q;
    end
  end

  // Datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      mode_q       <= MODE_ZEROS;
      pos_q        <= '0;
      cur_q        <= '0;
      best_q       <= '0;
      best_start_q <= '0;
      run_length_q <= '0;
      run_start_q  <= '0;
    end else begin
      shift_q      <= shift_d;
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      cur_q        <= cur_d;
      best_q       <= best_d;
      best_start_q <= best_start_d;
      run_length_q <= run_length_d;
      run_start_q  <= run_start_d;
    end
  end

  assign bus.run_length = run_length_q;
  assign bus.run_start  = run_start_q;

endmodule
